// File: rtl/locked_cla_pipe_if.sv
// Operand/result stream and serial key port of the locked CLA pipeline.
// The master side drives operands and key bits; the slave side is the adder.
interface locked_cla_pipe_if #(
    parameter int WIDTH = 16
);
    logic             key_sen;
    logic             key_sin;
    logic             key_loaded;
    logic             key_busy;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result_o;

    modport master (
        output key_sen, key_sin, in_valid, add1_i, add2_i, out_ready,
        input  key_loaded, key_busy, in_ready, out_valid, result_o
    );

    modport slave (
        input  key_sen, key_sin, in_valid, add1_i, add2_i, out_ready,
        output key_loaded, key_busy, in_ready, out_valid, result_o
    );
endinterface

// File: rtl/locked_cla_pipe.sv
// Key-locked pipelined carry-lookahead adder with serial key load.
// A new key only takes effect once the pipeline is empty.

// One 4-bit lookahead block: all internal carries from p/g/cin directly.
module locked_cla_blk (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | ((&p) & cin);
    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module locked_cla_pipe #(
    parameter int              WIDTH      = 16,
    parameter int              KEY_W      = 2 * WIDTH,
    parameter logic [KEY_W-1:0] KEY_GOLDEN = KEY_W'(32'hF17B83DB),
    parameter int              STAGES     = 2
) (
    input logic               clk,
    input logic               rst_n,
    locked_cla_pipe_if.slave  bus
);
    localparam int NB = WIDTH / 4;
    localparam int CW = $clog2(KEY_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} key_state_e;

    key_state_e        state_q, state_d;
    logic [KEY_W-1:0]  shadow_q, active_q;
    logic [CW-1:0]     cnt_q;
    logic              loaded_q;
    logic              shift_en, commit_en;

    logic [STAGES:1]            vld_q, vld_in, ld_en;
    logic [STAGES:1][WIDTH:0]   data_q, din;
    logic                       pipe_empty, in_ready, in_fire;

    assign pipe_empty = ~|vld_q;

    // ---------------- key FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.key_sen) begin
                    shift_en = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (bus.key_sen) begin
                    shift_en = 1'b1;
                    if (cnt_q == CW'(KEY_W - 1)) state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (pipe_empty) begin
                    commit_en = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            if (shift_en) begin
                shadow_q <= {shadow_q[KEY_W-2:0], bus.key_sin};
                cnt_q    <= (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
            end
            if (commit_en) begin
                active_q <= shadow_q;
                loaded_q <= 1'b1;
                cnt_q    <= '0;
            end
        end
    end

    // ---------------- locked CLA (input stage) ----------------
    logic [KEY_W-1:0] k_eff;
    logic [WIDTH-1:0] p_l, g_l, sum_s;
    logic [NB:0]      bc;

    assign k_eff = active_q ^ KEY_GOLDEN;
    assign p_l   = (bus.add1_i ^ bus.add2_i) ^ k_eff[WIDTH-1:0];
    assign g_l   = (bus.add1_i & bus.add2_i) ^ k_eff[KEY_W-1:WIDTH];
    assign bc[0] = 1'b0;

    for (genvar b = 0; b < NB; b++) begin : g_blk
        locked_cla_blk u_blk (
            .p    (p_l[4*b +: 4]),
            .g    (g_l[4*b +: 4]),
            .cin  (bc[b]),
            .s    (sum_s[4*b +: 4]),
            .cout (bc[b+1])
        );
    end

    // ---------------- stall-able pipeline ----------------
    // A stage may load when empty or when everything downstream of it moves.
    always_comb begin
        ld_en         = '0;
        ld_en[STAGES] = ~vld_q[STAGES] | bus.out_ready;
        for (int s = STAGES - 1; s >= 1; s--)
            ld_en[s] = ~vld_q[s] | ld_en[s+1];
    end

    assign in_ready = (state_q != COMMIT) & ld_en[1];
    assign in_fire  = bus.in_valid & in_ready;

    always_comb begin
        vld_in    = '0;
        din       = '0;
        vld_in[1] = in_fire;
        din[1]    = {bc[NB], sum_s};
        for (int s = 2; s <= STAGES; s++) begin
            vld_in[s] = vld_q[s-1];
            din[s]    = data_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                if (ld_en[s]) begin
                    vld_q[s] <= vld_in[s];
                    if (vld_in[s]) data_q[s] <= din[s];
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = vld_q[STAGES];
    assign bus.result_o   = data_q[STAGES];
    assign bus.key_loaded = loaded_q;
    assign bus.key_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_locked_cla_pipe.sv
// Directed bench for locked_cla_pipe: vector table plus key-load corner sequences.
module tb_locked_cla_pipe;
    localparam int          W    = 16;
    localparam logic [31:0] GOLD = 32'hF17B83DB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    locked_cla_pipe_if #(.WIDTH(W)) bus ();

    locked_cla_pipe #(
        .WIDTH      (W),
        .KEY_W      (32),
        .KEY_GOLDEN (GOLD),
        .STAGES     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] exp;
    } vec_t;

    vec_t        vecs[7];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] q[$];
    logic [16:0] held;
    logic [16:0] e;
    bit          hold;
    bit          pat[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifts the top nbits of key MSB first; gap idle cycles between shifts.
    task automatic shift_key(input logic [31:0] key, input int gap, input int nbits,
                             output int busy_cnt);
        busy_cnt = 0;
        for (int i = 31; i > 31 - nbits; i--) begin
            bus.key_sen = 1'b1;
            bus.key_sin = key[i];
            tick();
            if (bus.key_busy) busy_cnt++;
            bus.key_sen = 1'b0;
            bus.key_sin = ~key[i];
            repeat (gap) tick();
        end
    endtask

    task automatic wait_idle(input string nm, output int n);
        n = 0;
        while (bus.key_busy && n < 200) begin
            tick();
            n++;
        end
        chk(nm, bus.key_busy, 0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] exp, input string nm);
        bus.out_ready = 1'b1;
        bus.add1_i    = a;
        bus.add2_i    = b;
        bus.in_valid  = 1'b1;
        #1;
        chk({nm, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk({nm, "_lat1_valid"}, bus.out_valid, 0);
        tick();
        chk({nm, "_lat2_valid"}, bus.out_valid, 1);
        chk({nm, "_sum"}, bus.result_o, exp);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("%s_v%0d", tag, i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bc, nc, got, sent, cyc;

        vecs[0] = '{16'h29AF, 16'h7A1B, 17'h0A3CA};
        vecs[1] = '{16'h8943, 16'hFFFF, 17'h18942};
        vecs[2] = '{16'h5555, 16'hAAAA, 17'h0FFFF};
        vecs[3] = '{16'hFFFF, 16'h0001, 17'h10000};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[5] = '{16'h0000, 16'h0000, 17'h00000};
        vecs[6] = '{16'h1234, 16'h4321, 17'h05555};
        pat     = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n         = 1'b0;
        bus.key_sen   = 1'b0;
        bus.key_sin   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.add1_i    = '0;
        bus.add2_i    = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_key_loaded", bus.key_loaded, 0);
        chk("rst_key_busy", bus.key_busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result_o, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // First golden key load on an empty pipeline
        shift_key(GOLD, 0, 32, bc);
        chk("load_busy_cycles", bc, 32);
        chk("load_not_yet_loaded", bus.key_loaded, 0);
        chk("commit_in_ready", bus.in_ready, 0);
        wait_idle("load_idle", nc);
        chk("commit_cycles", nc, 1);
        chk("load_loaded", bus.key_loaded, 1);
        run_table("gold");

        // Wrong keys: bit 0 flips p'[0], bit 16 flips g'[0]
        shift_key(32'hF17B83DA, 0, 32, bc);
        wait_idle("wk0_idle", nc);
        run_op(16'h0000, 16'h0001, 17'h00000, "wrongkey_b0");
        shift_key(32'hF17A83DB, 0, 32, bc);
        wait_idle("wk16_idle", nc);
        run_op(16'h0000, 16'h0000, 17'h00002, "wrongkey_b16");
        shift_key(GOLD, 0, 32, bc);
        wait_idle("regold_idle", nc);

        // Back-to-back with out_ready pattern 1,0,0,1
        got = 0; sent = 0; cyc = 0; hold = 1'b0;
        q.delete();
        while (got < 16 && cyc < 300) begin
            bus.out_ready = pat[cyc % 4];
            if (sent < 16) begin
                bus.in_valid = 1'b1;
                bus.add1_i   = 16'(sent * 16'h1357 + 16'h0F0F);
                bus.add2_i   = 16'(sent * 16'h2468 + 16'hF000);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (hold) begin
                chk("b2b_stall_valid", bus.out_valid, 1);
                chk("b2b_stall_hold", bus.result_o, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("b2b_unexpected", 1, 0);
                else               chk("b2b_data", bus.result_o, q.pop_front());
                got++;
                hold = 1'b0;
            end else if (bus.out_valid) begin
                hold = 1'b1;
                held = bus.result_o;
            end else begin
                hold = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                e = {1'b0, bus.add1_i} + {1'b0, bus.add2_i};
                q.push_back(e);
                sent++;
            end
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("b2b_got", got, 16);
        chk("b2b_sent", sent, 16);
        tick();
        chk("b2b_no_dup", bus.out_valid, 0);

        // Key load while two results are stalled in the pipe
        bus.out_ready = 1'b0;
        bus.add1_i    = 16'h1234;
        bus.add2_i    = 16'h1111;
        bus.in_valid  = 1'b1;
        tick();
        bus.add1_i = 16'hFFFF;
        bus.add2_i = 16'h0001;
        tick();
        bus.in_valid = 1'b0;
        shift_key(32'hF17B83DA, 0, 32, bc);
        bus.in_valid = 1'b1;
        repeat (3) tick();
        chk("inflight_in_ready", bus.in_ready, 0);
        chk("inflight_busy", bus.key_busy, 1);
        bus.in_valid = 1'b0;
        chk("inflight_hold_valid", bus.out_valid, 1);
        chk("inflight_r0", bus.result_o, 17'h02345);
        bus.out_ready = 1'b1;
        tick();
        chk("inflight_r1_valid", bus.out_valid, 1);
        chk("inflight_r1", bus.result_o, 17'h10000);
        chk("inflight_still_busy", bus.key_busy, 1);
        tick();
        chk("inflight_drained", bus.out_valid, 0);
        wait_idle("inflight_idle", nc);
        chk("inflight_commit_cycles", nc, 1);
        run_op(16'h0000, 16'h0001, 17'h00000, "inflight_newkey");
        shift_key(GOLD, 0, 32, bc);
        wait_idle("inflight_regold", nc);

        // Reset in the middle of a load with a result pending
        bus.out_ready = 1'b0;
        bus.add1_i    = 16'h0001;
        bus.add2_i    = 16'h0002;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", bus.out_valid, 1);
        shift_key(GOLD, 0, 10, bc);
        rst_n = 1'b0;
        #1;
        chk("midrst_loaded", bus.key_loaded, 0);
        chk("midrst_busy", bus.key_busy, 0);
        chk("midrst_valid", bus.out_valid, 0);
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("postrst_in_ready", bus.in_ready, 1);
        chk("postrst_loaded", bus.key_loaded, 0);

        // Gapped load: one shift every 3 cycles
        shift_key(GOLD, 2, 32, bc);
        wait_idle("gap_idle", nc);
        chk("gap_loaded", bus.key_loaded, 1);
        run_table("gap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
